// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
// Optional feature macro: MULDIV_FAST_MULT_EN (single-cycle multiplier).
package muldiv_ctrl_pkg;

  localparam int unsigned ITER_CNT   = 32;
  localparam int unsigned DATA_W_DEF = ITER_CNT;
  localparam int unsigned CNT_W_DEF  = 6;

  // Quotient reported for a divide by zero.
  localparam logic [DATA_W_DEF-1:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // {op_div, op_signed}
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_iter_core.sv
// Radix-2 iterative engine: 2*DATA_W shift register {hi,lo} plus one adder/subtractor.
// Multiply: lo holds the multiplier, m the multiplicand (shift-add, shift right).
// Divide:   lo holds the dividend, m the divisor (restoring, shift left).
module muldiv_ctrl_iter_core
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              mode_div,
  input  logic [DATA_W-1:0] load_a,
  input  logic [DATA_W-1:0] load_b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int unsigned AW = DATA_W + 1;

  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [AW-1:0]     base_c, addend_c, sum_c;

  // Shared adder: partial-product add for multiply, trial subtract for divide.
  always_comb begin
    base_c   = mode_div ? {hi_q, lo_q[DATA_W-1]} : {1'b0, hi_q};
    addend_c = '0;
    if (mode_div) begin
      addend_c = ~{1'b0, m_q};
    end else if (lo_q[0]) begin
      addend_c = {1'b0, m_q};
    end
    sum_c = base_c + addend_c + AW'(mode_div);
  end

  // Next value of the shift register and operand latch.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    m_d  = m_q;
    if (load) begin
      hi_d = '0;
      lo_d = load_a;
      m_d  = load_b;
    end else if (step) begin
      if (mode_div) begin
        // sum_c[DATA_W] set means the trial subtract borrowed: keep the shifted value.
        hi_d = sum_c[DATA_W] ? base_c[DATA_W-1:0] : sum_c[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], ~sum_c[DATA_W]};
      end else begin
        hi_d = sum_c[DATA_W:1];
        lo_d = {sum_c[0], lo_q[DATA_W-1:1]};
      end
    end
  end

  // Engine registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign res_hi = hi_q;
  assign res_lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, stalls EX while the iterative engine runs.
// Optional feature macro: MULDIV_FAST_MULT_EN (mult/multu complete in IDLE, no stall).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_div,
  input  logic              op_signed,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              annul,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] mt_wdata,
  output logic              stallreq_for_ex,
  output logic              busy,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned PW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic              dz_q, dz_d;
  logic              s2_sign_q, s2_sign_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic              s1_neg_c, s2_neg_c, accept_c;
  logic [DATA_W-1:0] src1_mag_c, src2_mag_c;
  logic              core_load_c, core_step_c;
  logic [DATA_W-1:0] core_a_c, core_b_c, core_hi, core_lo;
  logic              neg_lo_c, neg_hi_c;
  logic [PW-1:0]     prod_c;
  logic [DATA_W-1:0] quot_c, rem_c, res_hi_c, res_lo_c;

  // Operand magnitudes for the unsigned engine.
  always_comb begin
    s1_neg_c   = op_signed & src1[DATA_W-1];
    s2_neg_c   = op_signed & src2[DATA_W-1];
    src1_mag_c = s1_neg_c ? (~src1 + DATA_W'(1)) : src1;
    src2_mag_c = s2_neg_c ? (~src2 + DATA_W'(1)) : src2;
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [PW-1:0] fast_mag_c, fast_res_c;

  // Single-cycle multiplier; sign fixup as for the iterative path.
  always_comb begin
    fast_mag_c = PW'(src1_mag_c) * PW'(src2_mag_c);
    fast_res_c = (s1_neg_c ^ s2_neg_c) ? (~fast_mag_c + PW'(1)) : fast_mag_c;
  end

  assign accept_c = op_valid & ~annul & op_div;
`else
  assign accept_c = op_valid & ~annul;
`endif

  // Multiply loads the multiplier into the shift register; divide loads the dividend.
  assign core_a_c = op_div ? src1_mag_c : src2_mag_c;
  assign core_b_c = op_div ? src2_mag_c : src1_mag_c;

  muldiv_ctrl_iter_core #(
    .DATA_W (DATA_W)
  ) u_iter_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load_c),
    .step     (core_step_c),
    .mode_div (op_is_div(op_q)),
    .load_a   (core_a_c),
    .load_b   (core_b_c),
    .res_hi   (core_hi),
    .res_lo   (core_lo)
  );

  // Sign fixup of the raw magnitude result; divide-by-zero overrides it.
  always_comb begin
    neg_lo_c = op_is_signed(op_q) & (dividend_q[DATA_W-1] ^ s2_sign_q);
    neg_hi_c = op_is_signed(op_q) & dividend_q[DATA_W-1];
    prod_c   = {core_hi, core_lo};
    if (neg_lo_c) begin
      prod_c = ~prod_c + PW'(1);
    end
    quot_c = neg_lo_c ? (~core_lo + DATA_W'(1)) : core_lo;
    rem_c  = neg_hi_c ? (~core_hi + DATA_W'(1)) : core_hi;
    if (dz_q) begin
      res_hi_c = dividend_q;
      res_lo_c = DATA_W'(DIVZERO_QUOT);
    end else if (op_is_div(op_q)) begin
      res_hi_c = rem_c;
      res_lo_c = quot_c;
    end else begin
      res_hi_c = prod_c[PW-1:DATA_W];
      res_lo_c = prod_c[DATA_W-1:0];
    end
  end

  // Next state, stall request and HI/LO update; a completing operation beats mthi/mtlo.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    dz_d            = dz_q;
    s2_sign_d       = s2_sign_q;
    dividend_d      = dividend_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    stallreq_for_ex = 1'b0;
    core_load_c     = 1'b0;
    core_step_c     = 1'b0;

    if (mthi_we) hi_d = mt_wdata;
    if (mtlo_we) lo_d = mt_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          stallreq_for_ex = 1'b1;
          core_load_c     = 1'b1;
          op_d            = op_e'({op_div, op_signed});
          s2_sign_d       = src2[DATA_W-1];
          dividend_d      = src1;
          cnt_d           = '0;
          dz_d            = op_div & (src2 == '0);
          state_d         = (op_div && (src2 == '0)) ? ST_DIVZERO : ST_RUN;
        end
`ifdef MULDIV_FAST_MULT_EN
        if (op_valid && !annul && !op_div) begin
          hi_d = fast_res_c[PW-1:DATA_W];
          lo_d = fast_res_c[DATA_W-1:0];
        end
`endif
      end
      ST_DIVZERO: begin
        if (annul) begin
          state_d = ST_IDLE;
        end else begin
          stallreq_for_ex = 1'b1;
          state_d         = ST_DONE;
        end
      end
      ST_RUN: begin
        if (annul) begin
          state_d = ST_IDLE;
        end else begin
          stallreq_for_ex = 1'b1;
          core_step_c     = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!annul) begin
          hi_d = res_hi_c;
          lo_d = res_lo_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULTU;
      dz_q       <= 1'b0;
      s2_sign_q  <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dz_q       <= dz_d;
      s2_sign_q  <= s2_sign_d;
      dividend_q <= dividend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver pushes expected HI/LO, monitor checks when busy falls.
module tb_muldiv_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0, op_div = 1'b0, op_signed = 1'b0, annul = 1'b0;
  logic         mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [W-1:0] src1 = '0, src2 = '0, mt_wdata = '0;
  logic         stallreq_for_ex, busy;
  logic [W-1:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic           prev_busy = 1'b0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_div          (op_div),
    .op_signed       (op_signed),
    .src1            (src1),
    .src2            (src2),
    .annul           (annul),
    .mthi_we         (mthi_we),
    .mtlo_we         (mtlo_we),
    .mt_wdata        (mt_wdata),
    .stallreq_for_ex (stallreq_for_ex),
    .busy            (busy),
    .hi_o            (hi_o),
    .lo_o            (lo_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input bit div, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!div) begin
      if (sgn) begin
        p   = sa * sb;
        res = p;
      end else begin
        res = {32'b0, a} * {32'b0, b};
      end
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 20));
      1:       v = -32'($urandom_range(1, 20));
      2:       v = 32'h8000_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Issue one operation; annul_at/rst_at > 0 abort it at that stall-cycle count.
  task automatic do_op(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input int annul_at, input int rst_at, input bit mthi_at_done);
    logic [63:0] r;
    int cnt;
    int exp_cnt;
    bit done;
    r = ref_result(div, sgn, a, b);
    if (annul_at > 0)            exp_cnt = annul_at;
    else if (div && b == 32'd0)  exp_cnt = 2;
    else                         exp_cnt = 33;
    @(negedge clk);
    op_valid = 1'b1; op_div = div; op_signed = sgn; src1 = a; src2 = b;
    if (annul_at > 0) begin
      exp_q.push_back({m_hi, m_lo});
    end else if (rst_at > 0) begin
      exp_q.push_back('0);
      m_hi = '0; m_lo = '0;
    end else begin
      exp_q.push_back(r);
      {m_hi, m_lo} = r;
    end
    cnt  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (annul_at > 0 && cnt == annul_at) annul = 1'b1;
      if (rst_at > 0 && cnt == rst_at) rst = 1'b1;
      #1;
      if (rst) begin
        done = 1'b1;
      end else if (!stallreq_for_ex) begin
        done = 1'b1;
        check("busy_at_release", 64'(busy), 64'd1);
        if (mthi_at_done) begin
          mthi_we = 1'b1; mt_wdata = 32'hA5A5_A5A5;
        end
      end else begin
        cnt++;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL op_timeout: actual no release after 100 cycles required release");
    end
    if (rst_at == 0) check("stall_cycles", 64'(cnt), 64'(exp_cnt));
    // op_valid stays high through DONE; it must be ignored there.
    @(negedge clk);
    op_valid = 1'b0; annul = 1'b0; rst = 1'b0; mthi_we = 1'b0;
    #1 check("busy_after_op", 64'(busy), 64'd0);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] d);
    @(negedge clk);
    mthi_we = to_hi; mtlo_we = !to_hi; mt_wdata = d;
    #1 check("mt_no_bypass", {hi_o, lo_o}, {m_hi, m_lo});
    if (to_hi) m_hi = d; else m_lo = d;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    #1 check("mt_write", {hi_o, lo_o}, {m_hi, m_lo});
  endtask

  // Monitor: HI/LO are final once busy falls (completion, annul or reset).
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL scoreboard_empty: actual hilo %0h required no completion", {hi_o, lo_o});
        end else begin
          e = exp_q.pop_front();
          check("hilo", {hi_o, lo_o}, e);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    bit div, sgn;
    logic [31:0] a, b;
    int ann;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stallreq_for_ex), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b1, 1'b0, 32'd100, 32'd7, 0, 0, 1'b0);
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b0);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b0);
    do_op(1'b1, 1'b1, 32'd5, 32'd0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 32'd1000, 32'd3, 10, 0, 1'b0);
    do_op(1'b1, 1'b0, 32'd77, 32'd5, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 32'd9, 32'd4, 0, 0, 1'b1);
    mt_write(1'b0, 32'h1234_5678);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      div = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = rand_operand();
      b   = rand_operand();
      if (div && $urandom_range(0, 7) == 0) b = 32'd0;
      ann = 0;
      if (!(div && b == 32'd0) && $urandom_range(0, 7) == 0) ann = $urandom_range(1, 32);
      do_op(div, sgn, a, b, ann, 0, 1'b0);
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), $urandom());
    end

    do_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 0, 5, 1'b0);
    do_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
